// File: rtl/voice_allocator.sv
// voice_allocator: maps note-on/note-off commands onto NUM_VOICES envelope/tone voices.
// Latency: a command accepted in cycle N is decided in N+1; gate/voice_note/pulses show at N+2.
// Backpressure: cmd_ready is low during the decide cycle, so at most one command every 2 cycles.
// Optional feature macro VOICE_STEAL_EN: when all voices are busy, steal the oldest instead of dropping.
module voice_allocator #(
  parameter int NUM_VOICES = 4,
  parameter int NOTE_BITS  = 7,
  parameter int GATE_GAP   = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic                            cmd_on,
  input  logic [NOTE_BITS-1:0]            cmd_note,
  input  logic [NUM_VOICES*8-1:0]         voice_amp,
  output logic [NUM_VOICES-1:0]           gate,
  output logic [NUM_VOICES*NOTE_BITS-1:0] voice_note,
  output logic                            cmd_dropped,
  output logic                            voice_stolen
);

  localparam int         IW  = $clog2(NUM_VOICES);
  localparam logic [3:0] GAP = 4'(GATE_GAP);

  typedef enum logic [1:0] {
    V_FREE      = 2'd0,
    V_ACTIVE    = 2'd1,
    V_RETRIG    = 2'd2,
    V_RELEASING = 2'd3
  } vstate_e;

  typedef enum logic {
    CMD_IDLE   = 1'b0,
    CMD_DECIDE = 1'b1
  } cmd_state_e;

  cmd_state_e           cst_q, cst_d;
  logic                 ready_q, ready_d;
  logic                 on_q, on_d;
  logic [NOTE_BITS-1:0] cnote_q, cnote_d;
  logic                 dropped_q, dropped_d;
  logic [NUM_VOICES-1:0] gate_q, gate_d;

  vstate_e              vst_q  [NUM_VOICES];
  vstate_e              vst_d  [NUM_VOICES];
  logic [3:0]           gap_q  [NUM_VOICES];
  logic [3:0]           gap_d  [NUM_VOICES];
  logic [3:0]           age_q  [NUM_VOICES];
  logic [3:0]           age_d  [NUM_VOICES];
  logic [NOTE_BITS-1:0] note_q [NUM_VOICES];
  logic [NOTE_BITS-1:0] note_d [NUM_VOICES];

  // candidate voices for each note-on rule, taken from start-of-cycle state
  logic          hit_vld, free_vld, rel_vld;
  logic [IW-1:0] hit_idx, free_idx, rel_idx;
  logic [3:0]    rel_age;

  // chosen allocation for this decide cycle
  logic          alloc_en, alloc_setnote, alloc_retrig;
  logic [IW-1:0] alloc_idx;

`ifdef VOICE_STEAL_EN
  logic          stolen_q, stolen_d;
  logic          busy_vld;
  logic [IW-1:0] busy_idx;
  logic [3:0]    busy_age;

  // oldest ACTIVE/RETRIG voice; strict compare keeps the lowest index on ties
  always_comb begin
    busy_vld = 1'b0;
    busy_idx = '0;
    busy_age = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if ((vst_q[i] == V_ACTIVE || vst_q[i] == V_RETRIG) &&
          (!busy_vld || age_q[i] > busy_age)) begin
        busy_vld = 1'b1;
        busy_idx = IW'(i);
        busy_age = age_q[i];
      end
    end
  end

  assign voice_stolen = stolen_q;
`else
  assign voice_stolen = 1'b0;
`endif

  // rule 1/2/3 candidates: matching busy voice, first free voice, oldest releasing voice
  always_comb begin
    hit_vld  = 1'b0;
    hit_idx  = '0;
    free_vld = 1'b0;
    free_idx = '0;
    rel_vld  = 1'b0;
    rel_idx  = '0;
    rel_age  = '0;
    // descending scan so the lowest index is the last one written
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if (vst_q[i] != V_FREE && note_q[i] == cnote_q) begin
        hit_vld = 1'b1;
        hit_idx = IW'(i);
      end
      if (vst_q[i] == V_FREE) begin
        free_vld = 1'b1;
        free_idx = IW'(i);
      end
    end
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (vst_q[i] == V_RELEASING && (!rel_vld || age_q[i] > rel_age)) begin
        rel_vld = 1'b1;
        rel_idx = IW'(i);
        rel_age = age_q[i];
      end
    end
  end

  // next state: per-voice autonomous moves first, then the command decision overrides
  always_comb begin
    cst_d         = cst_q;
    on_d          = on_q;
    cnote_d       = cnote_q;
    dropped_d     = 1'b0;
    alloc_en      = 1'b0;
    alloc_idx     = '0;
    alloc_setnote = 1'b0;
    alloc_retrig  = 1'b0;
`ifdef VOICE_STEAL_EN
    stolen_d      = 1'b0;
`endif
    for (int i = 0; i < NUM_VOICES; i++) begin
      vst_d[i]  = vst_q[i];
      gap_d[i]  = gap_q[i];
      age_d[i]  = age_q[i];
      note_d[i] = note_q[i];
      case (vst_q[i])
        V_RETRIG: begin
          if (gap_q[i] <= 4'd1) vst_d[i] = V_ACTIVE;
          else                  gap_d[i] = gap_q[i] - 4'd1;
        end
        V_RELEASING: begin
          if (voice_amp[8*i +: 8] == 8'd0) vst_d[i] = V_FREE;
        end
        default: ;
      endcase
    end

    case (cst_q)
      CMD_IDLE: begin
        if (cmd_valid && ready_q) begin
          cst_d   = CMD_DECIDE;
          on_d    = cmd_on;
          cnote_d = cmd_note;
        end
      end
      CMD_DECIDE: begin
        cst_d = CMD_IDLE;
        if (on_q) begin
          if (hit_vld) begin
            alloc_en     = 1'b1;
            alloc_idx    = hit_idx;
            alloc_retrig = 1'b1;
          end else if (free_vld) begin
            alloc_en      = 1'b1;
            alloc_idx     = free_idx;
            alloc_setnote = 1'b1;
          end else if (rel_vld) begin
            alloc_en      = 1'b1;
            alloc_idx     = rel_idx;
            alloc_setnote = 1'b1;
            alloc_retrig  = 1'b1;
          end else begin
`ifdef VOICE_STEAL_EN
            alloc_en      = busy_vld;
            alloc_idx     = busy_idx;
            alloc_setnote = 1'b1;
            alloc_retrig  = 1'b1;
            stolen_d      = busy_vld;
`else
            dropped_d     = 1'b1;
`endif
          end
        end else begin
          for (int i = 0; i < NUM_VOICES; i++) begin
            if ((vst_q[i] == V_ACTIVE || vst_q[i] == V_RETRIG) && note_q[i] == cnote_q)
              vst_d[i] = V_RELEASING;
          end
        end
      end
      default: cst_d = CMD_IDLE;
    endcase

    if (alloc_en) begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        if (alloc_idx == IW'(i)) begin
          age_d[i] = 4'd0;
          gap_d[i] = GAP;
          vst_d[i] = alloc_retrig ? V_RETRIG : V_ACTIVE;
          if (alloc_setnote) note_d[i] = cnote_q;
        end else if (vst_q[i] != V_FREE && age_q[i] != 4'd15) begin
          age_d[i] = age_q[i] + 4'd1;
        end
      end
    end

    ready_d = (cst_d == CMD_IDLE);
    for (int i = 0; i < NUM_VOICES; i++) gate_d[i] = (vst_d[i] == V_ACTIVE);
  end

  // all state registers, cleared by synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      cst_q     <= CMD_IDLE;
      ready_q   <= 1'b0;
      on_q      <= 1'b0;
      cnote_q   <= '0;
      dropped_q <= 1'b0;
      gate_q    <= '0;
`ifdef VOICE_STEAL_EN
      stolen_q  <= 1'b0;
`endif
      for (int i = 0; i < NUM_VOICES; i++) begin
        vst_q[i]  <= V_FREE;
        gap_q[i]  <= '0;
        age_q[i]  <= '0;
        note_q[i] <= '0;
      end
    end else begin
      cst_q     <= cst_d;
      ready_q   <= ready_d;
      on_q      <= on_d;
      cnote_q   <= cnote_d;
      dropped_q <= dropped_d;
      gate_q    <= gate_d;
`ifdef VOICE_STEAL_EN
      stolen_q  <= stolen_d;
`endif
      for (int i = 0; i < NUM_VOICES; i++) begin
        vst_q[i]  <= vst_d[i];
        gap_q[i]  <= gap_d[i];
        age_q[i]  <= age_d[i];
        note_q[i] <= note_d[i];
      end
    end
  end

  // flatten per-voice notes onto the output bus
  always_comb begin
    voice_note = '0;
    for (int i = 0; i < NUM_VOICES; i++) voice_note[NOTE_BITS*i +: NOTE_BITS] = note_q[i];
  end

  assign cmd_ready   = ready_q;
  assign gate        = gate_q;
  assign cmd_dropped = dropped_q;

endmodule

// File: tb/tb_voice_allocator.sv
// tb_voice_allocator: directed test-plan sequences followed by random commands and envelope levels.
// The driver updates an abstract voice model at every clock edge and queues the expected outputs;
// a monitor pops one expectation per cycle and compares every output.
module tb_voice_allocator;
  localparam int NV  = 4;
  localparam int NB  = 7;
  localparam int GAP = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cmd_valid = 1'b0;
  logic              cmd_on = 1'b0;
  logic [NB-1:0]     cmd_note = '0;
  logic [NV*8-1:0]   voice_amp = '0;
  logic              cmd_ready;
  logic [NV-1:0]     gate;
  logic [NV*NB-1:0]  voice_note;
  logic              cmd_dropped;
  logic              voice_stolen;

  voice_allocator #(.NUM_VOICES(NV), .NOTE_BITS(NB), .GATE_GAP(GAP)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_on(cmd_on), .cmd_note(cmd_note), .voice_amp(voice_amp), .gate(gate),
    .voice_note(voice_note), .cmd_dropped(cmd_dropped), .voice_stolen(voice_stolen)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NV-1:0]    gate;
    logic [NV*NB-1:0] notes;
    logic             dropped;
    logic             stolen;
    logic             ready;
    int               edge_no;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  // abstract model: a voice is held (gate wanted), releasing, or free; gate shows once rise edge is reached
  bit [NV-1:0] m_held, m_rel;
  int          m_note [NV];
  int          m_age  [NV];
  int          m_rise [NV];
  bit          m_ready, m_pend, m_pon;
  int          m_pnote;
  int          e_cnt = 0;
  logic [NV*8-1:0] amp_cur = '0;

  function automatic void chk(input string nm, input int e, input logic [63:0] act, input logic [63:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s after edge %0d: got %0h expected %0h", nm, e, act, expv);
    end
  endfunction

  function automatic int oldest(input bit [NV-1:0] mask);
    int best = -1;
    for (int i = 0; i < NV; i++)
      if (mask[i] && (best < 0 || m_age[i] > m_age[best])) best = i;
    return best;
  endfunction

  task automatic model_edge(input bit r, input bit v, input bit on, input int n, input logic [NV*8-1:0] amp);
    bit [NV-1:0] h0, r0;
    int   tgt;
    bit   retr, setn, drp, stl, acc;
    exp_t ex;
    e_cnt++;
    drp = 1'b0;
    stl = 1'b0;
    if (r) begin
      m_held = '0;
      m_rel  = '0;
      for (int i = 0; i < NV; i++) begin
        m_note[i] = 0; m_age[i] = 0; m_rise[i] = 0;
      end
      m_ready = 1'b0;
      m_pend  = 1'b0;
    end else begin
      h0 = m_held;
      r0 = m_rel;
      for (int i = 0; i < NV; i++)
        if (r0[i] && amp[8*i +: 8] == 8'd0) m_rel[i] = 1'b0;
      if (m_pend) begin
        if (m_pon) begin
          tgt = -1; retr = 1'b0; setn = 1'b0;
          for (int i = 0; i < NV; i++)
            if (tgt < 0 && (h0[i] || r0[i]) && m_note[i] == m_pnote) begin tgt = i; retr = 1'b1; end
          if (tgt < 0)
            for (int i = 0; i < NV; i++)
              if (tgt < 0 && !h0[i] && !r0[i]) begin tgt = i; setn = 1'b1; end
          if (tgt < 0) begin
            tgt = oldest(r0);
            if (tgt >= 0) begin setn = 1'b1; retr = 1'b1; end
          end
          if (tgt < 0) begin
`ifdef VOICE_STEAL_EN
            tgt = oldest(h0); setn = 1'b1; retr = 1'b1; stl = 1'b1;
`else
            drp = 1'b1;
`endif
          end
          if (tgt >= 0) begin
            for (int j = 0; j < NV; j++)
              if (j != tgt && (h0[j] || r0[j]) && m_age[j] < 15) m_age[j]++;
            m_age[tgt]  = 0;
            m_held[tgt] = 1'b1;
            m_rel[tgt]  = 1'b0;
            if (setn) m_note[tgt] = m_pnote;
            m_rise[tgt] = retr ? e_cnt + GAP : e_cnt;
          end
        end else begin
          for (int i = 0; i < NV; i++)
            if (h0[i] && m_note[i] == m_pnote) begin m_held[i] = 1'b0; m_rel[i] = 1'b1; end
        end
      end
      acc    = v && m_ready;
      m_pend = acc;
      if (acc) begin m_pon = on; m_pnote = n; end
      m_ready = !acc;
    end
    for (int i = 0; i < NV; i++) begin
      ex.gate[i] = m_held[i] && (e_cnt >= m_rise[i]);
      ex.notes[NB*i +: NB] = m_note[i][NB-1:0];
    end
    ex.dropped = drp;
    ex.stolen  = stl;
    ex.ready   = m_ready;
    ex.edge_no = e_cnt;
    exp_q.push_back(ex);
  endtask

  // monitor: one expectation per cycle, checked mid-cycle
  always @(negedge clk) begin
    exp_t ex;
    if (exp_q.size() > 0) begin
      ex = exp_q.pop_front();
      chk("gate",         ex.edge_no, 64'(gate),         64'(ex.gate));
      chk("voice_note",   ex.edge_no, 64'(voice_note),   64'(ex.notes));
      chk("cmd_dropped",  ex.edge_no, 64'(cmd_dropped),  64'(ex.dropped));
      chk("voice_stolen", ex.edge_no, 64'(voice_stolen), 64'(ex.stolen));
      chk("cmd_ready",    ex.edge_no, 64'(cmd_ready),    64'(ex.ready));
    end
  end

  task automatic step(input bit r, input bit v, input bit on, input int n);
    @(negedge clk);
    rst       = r;
    cmd_valid = v;
    cmd_on    = on;
    cmd_note  = n[NB-1:0];
    voice_amp = amp_cur;
    @(posedge clk);
    model_edge(r, v, on, n, amp_cur);
  endtask

  task automatic idle(input int cycles);
    for (int k = 0; k < cycles; k++) step(1'b0, 1'b0, 1'b0, 0);
  endtask

  task automatic cmd(input bit on, input int n);
    step(1'b0, 1'b1, on, n);
    step(1'b0, 1'b0, 1'b0, 0);
  endtask

  task automatic do_reset(input int cycles);
    for (int k = 0; k < cycles; k++) step(1'b1, 1'b0, 1'b0, 0);
    idle(1);
  endtask

  initial begin
    int nt;
    amp_cur = {NV{8'h80}};
    do_reset(3);

    // three allocations, a retrigger, a release that frees and is reused
    cmd(1'b1, 60); cmd(1'b1, 62); cmd(1'b1, 64);
    cmd(1'b1, 60); idle(3);
    cmd(1'b0, 62);
    amp_cur[15:8] = 8'h00; idle(2); amp_cur[15:8] = 8'h80;
    cmd(1'b1, 67); idle(2);

    // all voices busy, then one more note-on (steal or drop)
    do_reset(2);
    cmd(1'b1, 60); cmd(1'b1, 62); cmd(1'b1, 64); cmd(1'b1, 65);
    cmd(1'b1, 70); idle(4);
    cmd(1'b0, 99); idle(2);

    // reset while voice 2 is in its retrigger gap
    step(1'b0, 1'b1, 1'b1, 64);
    step(1'b0, 1'b0, 1'b0, 0);
    step(1'b1, 1'b0, 1'b0, 0);
    idle(3);

    // random commands, envelope levels and occasional reset
    for (int k = 0; k < 1500; k++) begin
      for (int i = 0; i < NV; i++)
        amp_cur[8*i +: 8] = ($urandom % 4 == 0) ? 8'h00 : 8'($urandom_range(1, 255));
      nt = ($urandom % 10 == 0) ? 99 : 60 + int'($urandom % 6);
      step(1'($urandom % 300 == 0), 1'($urandom % 2), 1'($urandom % 3 != 0), nt);
    end
    idle(3);

    @(negedge clk);
    #1;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
